// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus receiver.
// Holds the FSM state encoding, HD44780 command constants, parameter defaults,
// and the helper that computes the DDRAM address counter after a command byte.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_INIT8 = 2'd0,  // 8-bit power-on mode, waiting for the 4-bit function set
    ST_HI    = 2'd1,  // expecting the high nibble of a byte
    ST_LO    = 2'd2   // expecting the low nibble of a byte
  } lcd_state_t;

  localparam int MIN_EN_HIGH_DEFAULT = 12;
  localparam int SYNC_STAGES_DEFAULT = 2;

  localparam logic [7:0] CMD_CLEAR          = 8'h01;
  localparam logic [7:0] CMD_HOME           = 8'h02;
  localparam logic [7:0] CMD_SET_DDRAM_MASK = 8'h80;
  localparam logic [7:0] CMD_FUNC_SET       = 8'h20;  // function set family 0x2X/0x3X
  localparam logic [7:0] CMD_FUNC_SET_MASK  = 8'hE0;
  localparam logic [3:0] FUNC_SET_4BIT_NIB  = 4'h2;

  // Address counter value after a completed command byte.
  // HOME is 0x02 and 0x03 (bit 0 is don't-care), so compare bits [7:1].
  function automatic logic [6:0] lcd_cmd_addr(input logic [7:0] cmd, input logic [6:0] cur);
    logic [6:0] res;
    res = cur;
    if ((cmd & CMD_SET_DDRAM_MASK) != 8'h00) begin
      res = cmd[6:0];
    end else if (cmd == CMD_CLEAR || cmd[7:1] == CMD_HOME[7:1]) begin
      res = 7'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/lcd_bus_receiver_if.sv
// Bus bundle between an LCD host (master) and the receiver (slave).
// Inputs of the receiver: iLCD (DB7..DB4), iReadWrite, iRegisterSelect, iEnable.
// Outputs of the receiver: oByte, oIsData, oValid, oAddr, oMode4, oError,
// plus oState, the receiver FSM state for observation.
// Handshake: there is no back-pressure. The host strobes iEnable; a nibble is
// taken on the falling edge of a long-enough pulse. oValid is a single-cycle
// qualifier for oByte/oIsData/oAddr, which hold their value between pulses.
interface lcd_bus_receiver_if;
  import lcd_pkg::*;

  logic [3:0] iLCD;
  logic       iReadWrite;
  logic       iRegisterSelect;
  logic       iEnable;
  logic [7:0] oByte;
  logic       oIsData;
  logic       oValid;
  logic [6:0] oAddr;
  logic       oMode4;
  logic       oError;
  lcd_state_t oState;

  modport master (
    output iLCD, iReadWrite, iRegisterSelect, iEnable,
    input  oByte, oIsData, oValid, oAddr, oMode4, oError, oState
  );

  modport slave (
    input  iLCD, iReadWrite, iRegisterSelect, iEnable,
    output oByte, oIsData, oValid, oAddr, oMode4, oError, oState
  );
endinterface

// File: rtl/lcd_strobe_detect.sv
// Synchronizes the asynchronous LCD bus and detects enable strobes.
// Ports:
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   en_i, rs_i, rw_i     : raw iEnable / iRegisterSelect / iReadWrite
//   lcd_i[3:0]           : raw data nibble
//   strobe_o             : falling edge of a pulse at least MIN_EN_HIGH cycles long
//   short_o              : falling edge of a pulse that was too short
//   nib_o, rs_o, rw_o    : synchronized bus as seen in the last high cycle
module lcd_strobe_detect #(
  parameter int MIN_EN_HIGH = lcd_pkg::MIN_EN_HIGH_DEFAULT,
  parameter int SYNC_STAGES = lcd_pkg::SYNC_STAGES_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic [3:0] lcd_i,
  output logic       strobe_o,
  output logic       short_o,
  output logic [3:0] nib_o,
  output logic       rs_o,
  output logic       rw_o
);
  localparam int CW = $clog2(MIN_EN_HIGH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MIN_EN_HIGH);

  // All bus bits travel through one chain so enable and data stay aligned.
  // Packing: {en, rs, rw, lcd[3:0]}.
  logic [6:0]    sync_q [SYNC_STAGES];
  logic [6:0]    last_q;
  logic [CW-1:0] cnt_q;
  logic          live_q;
  logic          en_s;
  logic          fall;

  assign en_s = sync_q[SYNC_STAGES-1][6];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      last_q <= '0;
      cnt_q  <= '0;
      live_q <= 1'b0;
    end else begin
      sync_q[0] <= {en_i, rs_i, rw_i, lcd_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      last_q <= sync_q[SYNC_STAGES-1];
      // cnt_q equals the number of high cycles seen, saturating.
      if (en_s) begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
      live_q <= 1'b1;
    end
  end

  // live_q masks the first cycle after reset release.
  assign fall     = last_q[6] & ~en_s & live_q;
  assign strobe_o = fall & (cnt_q >= CNT_MAX);
  assign short_o  = fall & (cnt_q <  CNT_MAX);
  assign nib_o    = last_q[3:0];
  assign rs_o     = last_q[5];
  assign rw_o     = last_q[4];
endmodule

// File: rtl/lcd_bus_receiver.sv
// Receives HD44780-style 4-bit bus traffic and reassembles bytes.
// Ports:
//   Clock, Reset : clock, asynchronous active-high reset
//   bus (slave)  : LCD bus inputs and assembled byte outputs (see interface)
// The FSM starts in INIT8 where every strobe is a lone 8-bit-mode nibble; a
// function-set nibble 0x2 switches to 4-bit mode, after which bytes arrive as
// high/low nibble pairs. Completed write bytes update a 7-bit DDRAM counter.
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int MIN_EN_HIGH = MIN_EN_HIGH_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input logic            Clock,
  input logic            Reset,
  lcd_bus_receiver_if.slave bus
);
  logic       strobe;
  logic       short_pulse;
  logic [3:0] nib;
  logic       rs;
  logic       rw;

  lcd_strobe_detect #(
    .MIN_EN_HIGH(MIN_EN_HIGH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_strobe (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .en_i    (bus.iEnable),
    .rs_i    (bus.iRegisterSelect),
    .rw_i    (bus.iReadWrite),
    .lcd_i   (bus.iLCD),
    .strobe_o(strobe),
    .short_o (short_pulse),
    .nib_o   (nib),
    .rs_o    (rs),
    .rw_o    (rw)
  );

  lcd_state_t state_q;
  logic       mode4_q;
  logic       valid_q;
  logic       error_q;
  logic [7:0] byte_q;
  logic       is_data_q;
  logic [6:0] addr_q;
  logic [6:0] cnt_q;
  logic [3:0] hi_nib_q;
  logic       hi_rs_q;
  logic       hi_rw_q;

  logic [7:0] byte_d;
  logic       match_d;
  logic [6:0] cmd_addr_d;
  logic       func8_d;

  always_comb begin
    byte_d     = {hi_nib_q, nib};
    match_d    = (rs == hi_rs_q) && (rw == hi_rw_q);
    cmd_addr_d = lcd_cmd_addr(byte_d, cnt_q);
    // Function set with DL=1 drops the display back to 8-bit mode.
    func8_d    = ((byte_d & CMD_FUNC_SET_MASK) == CMD_FUNC_SET) && byte_d[4];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_INIT8;
      mode4_q   <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      byte_q    <= 8'h00;
      is_data_q <= 1'b0;
      addr_q    <= 7'h00;
      cnt_q     <= 7'h00;
      hi_nib_q  <= 4'h0;
      hi_rs_q   <= 1'b0;
      hi_rw_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= short_pulse;
      if (strobe) begin
        case (state_q)
          ST_INIT8: begin
            if (!rw && !rs && nib == FUNC_SET_4BIT_NIB) begin
              state_q <= ST_HI;
              mode4_q <= 1'b1;
            end
          end
          ST_HI: begin
            hi_nib_q <= nib;
            hi_rs_q  <= rs;
            hi_rw_q  <= rw;
            state_q  <= ST_LO;
          end
          ST_LO: begin
            if (match_d) begin
              state_q <= ST_HI;
              // Reads only advance the nibble phase.
              if (!hi_rw_q) begin
                byte_q    <= byte_d;
                is_data_q <= hi_rs_q;
                valid_q   <= 1'b1;
                if (hi_rs_q) begin
                  addr_q <= cnt_q;
                  cnt_q  <= cnt_q + 7'd1;  // wraps 0x7F -> 0x00
                end else begin
                  addr_q <= cmd_addr_d;
                  cnt_q  <= cmd_addr_d;
                  if (func8_d) begin
                    state_q <= ST_INIT8;
                    mode4_q <= 1'b0;
                  end
                end
              end
            end else begin
              // Mismatched RS/RW: the current nibble starts a new byte.
              error_q  <= 1'b1;
              hi_nib_q <= nib;
              hi_rs_q  <= rs;
              hi_rw_q  <= rw;
            end
          end
          default: state_q <= ST_INIT8;
        endcase
      end
    end
  end

  assign bus.oByte   = byte_q;
  assign bus.oIsData = is_data_q;
  assign bus.oValid  = valid_q;
  assign bus.oAddr   = addr_q;
  assign bus.oMode4  = mode4_q;
  assign bus.oError  = error_q;
  assign bus.oState  = state_q;
endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: linear sequence of nibble strobes with
// hand-computed expected bytes, addresses and error pulses.
module tb_lcd_bus_receiver;
  import lcd_pkg::*;

  logic Clock;
  logic Reset;

  lcd_bus_receiver_if bus ();

  lcd_bus_receiver #(
    .MIN_EN_HIGH(12),
    .SYNC_STAGES(2)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int compared   = 0;
  int mismatched = 0;

  // ---------------- scoreboard ----------------
  // Entries packed as {is_data, addr[6:0], byte[7:0]}.
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          err_cnt = 0;

  always @(negedge Clock) begin
    if (!Reset) begin
      if (bus.oValid === 1'b1) got_q.push_back({bus.oIsData, bus.oAddr, bus.oByte});
      if (bus.oError === 1'b1) err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expect exactly one assembled byte since the last check.
  task automatic check_valid(input string tag, input logic [15:0] exp);
    exp_q.push_back(exp);
    check({tag, "_count"}, 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    else void'(exp_q.pop_front());
    got_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic send_nib(input logic [3:0] nib, input logic rs, input logic rw, input int hi);
    bus.iLCD            = nib;
    bus.iRegisterSelect = rs;
    bus.iReadWrite      = rw;
    bus.iEnable         = 1'b0;
    wait_cyc(2);
    bus.iEnable = 1'b1;
    wait_cyc(hi);
    bus.iEnable = 1'b0;
    wait_cyc(8);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rs, input logic rw);
    send_nib(b[7:4], rs, rw, 20);
    send_nib(b[3:0], rs, rw, 20);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte"},   32'(bus.oByte),   32'h00);
    check({tag, "_isdata"}, 32'(bus.oIsData), 32'h0);
    check({tag, "_valid"},  32'(bus.oValid),  32'h0);
    check({tag, "_addr"},   32'(bus.oAddr),   32'h00);
    check({tag, "_mode4"},  32'(bus.oMode4),  32'h0);
    check({tag, "_error"},  32'(bus.oError),  32'h0);
    check({tag, "_state"},  32'(bus.oState),  32'(ST_INIT8));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.iLCD            = 4'h0;
    bus.iRegisterSelect = 1'b0;
    bus.iReadWrite      = 1'b0;
    bus.iEnable         = 1'b0;
    Reset               = 1'b1;
    wait_cyc(3);
    check_reset_outputs("rst");
    Reset = 1'b0;
    wait_cyc(2);

    // Power-on init nibbles.
    send_nib(4'h3, 1'b0, 1'b0, 20);
    send_nib(4'h3, 1'b0, 1'b0, 20);
    send_nib(4'h3, 1'b0, 1'b0, 20);
    check("init_mode4_pre", 32'(bus.oMode4), 32'h0);
    send_nib(4'h2, 1'b0, 1'b0, 20);
    check("init_mode4", 32'(bus.oMode4), 32'h1);
    check("init_state", 32'(bus.oState), 32'(ST_HI));
    check("init_novalid", 32'(got_q.size()), 32'd0);

    // Set DDRAM 0, two data bytes, then confirm counter reached 2.
    send_byte(8'h80, 1'b0, 1'b0);
    check_valid("cmd80", {1'b0, 7'h00, 8'h80});
    send_byte(8'h48, 1'b1, 1'b0);
    check_valid("data48", {1'b1, 7'h00, 8'h48});
    send_byte(8'h69, 1'b1, 1'b0);
    check_valid("data69", {1'b1, 7'h01, 8'h69});
    check("hold_byte", 32'(bus.oByte), 32'h69);
    send_byte(8'h21, 1'b1, 1'b0);
    check_valid("data21", {1'b1, 7'h02, 8'h21});

    // Address wrap.
    send_byte(8'hFF, 1'b0, 1'b0);
    check_valid("cmdFF", {1'b0, 7'h7F, 8'hFF});
    send_byte(8'h41, 1'b1, 1'b0);
    check_valid("data41", {1'b1, 7'h7F, 8'h41});
    send_byte(8'h42, 1'b1, 1'b0);
    check_valid("data42_wrap", {1'b1, 7'h00, 8'h42});

    // Short pulse between the nibbles of 0x57.
    send_nib(4'h5, 1'b1, 1'b0, 20);
    send_nib(4'hA, 1'b1, 1'b0, 5);
    check("short_err", 32'(err_cnt), 32'd1);
    check("short_state", 32'(bus.oState), 32'(ST_LO));
    check("short_novalid", 32'(got_q.size()), 32'd0);
    send_nib(4'h7, 1'b1, 1'b0, 20);
    check_valid("data57", {1'b1, 7'h01, 8'h57});

    // RS mismatch: high nibble RS=1, low nibble RS=0 becomes new high nibble.
    send_nib(4'h6, 1'b1, 1'b0, 20);
    send_nib(4'h1, 1'b0, 1'b0, 20);
    check("mism_err", 32'(err_cnt), 32'd2);
    check("mism_novalid", 32'(got_q.size()), 32'd0);
    check("mism_state", 32'(bus.oState), 32'(ST_LO));
    send_nib(4'h3, 1'b0, 1'b0, 20);
    check_valid("cmd13", {1'b0, 7'h02, 8'h13});

    // Read transaction: no output change.
    send_byte(8'h99, 1'b1, 1'b1);
    check("read_novalid", 32'(got_q.size()), 32'd0);
    check("read_state", 32'(bus.oState), 32'(ST_HI));
    check("read_hold", 32'(bus.oByte), 32'h13);
    check("err_total", 32'(err_cnt), 32'd2);

    // Reset after the high nibble of 0x41.
    send_nib(4'h4, 1'b1, 1'b0, 20);
    Reset = 1'b1;
    wait_cyc(2);
    check_reset_outputs("midrst");
    Reset = 1'b0;
    wait_cyc(2);
    send_nib(4'h1, 1'b1, 1'b0, 20);
    check("midrst_novalid", 32'(got_q.size()), 32'd0);
    check("midrst_state", 32'(bus.oState), 32'(ST_INIT8));

    // Re-enter 4-bit mode, then an 8-bit function set drops back to INIT8.
    send_nib(4'h2, 1'b0, 1'b0, 20);
    check("re_mode4", 32'(bus.oMode4), 32'h1);
    send_byte(8'h01, 1'b0, 1'b0);
    check_valid("cmd01", {1'b0, 7'h00, 8'h01});
    send_byte(8'h30, 1'b0, 1'b0);
    check_valid("cmd30", {1'b0, 7'h00, 8'h30});
    check("f8_mode4", 32'(bus.oMode4), 32'h0);
    check("f8_state", 32'(bus.oState), 32'(ST_INIT8));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
